// File: rtl/phcount_accumulator_pkg.sv
// Shared constants, state encoding and word helpers for the photon-counter
// frame accumulator.
package phcount_accumulator_pkg;

    localparam logic [15:0] HDR_LOG = 16'hFEED;  // logger frame header
    localparam logic [15:0] HDR_ACC = 16'hFEEA;  // accumulated frame header
    localparam logic [15:0] TERM    = 16'h0FED;  // frame terminator (both directions)

    localparam int NBINS_DEFAULT = 26;

    typedef enum logic [3:0] {
        ST_CLEAR     = 4'd0,
        ST_HUNT      = 4'd1,
        ST_ACC       = 4'd2,
        ST_EMIT_HDR  = 4'd3,
        ST_EMIT_HI   = 4'd4,
        ST_EMIT_LO   = 4'd5,
        ST_EMIT_CNT  = 4'd6,
        ST_EMIT_TERM = 4'd7
    } state_t;

    // The logger sends its bin words with the two bytes exchanged.
    function automatic logic [15:0] bswap16(input logic [15:0] w);
        return {w[7:0], w[15:8]};
    endfunction

endpackage

// File: rtl/phacc_ram.sv
// Per-bin accumulator storage: one synchronous write port, two asynchronous
// read ports (one for the accumulate path, one for the emit path).
module phacc_ram
    import phcount_accumulator_pkg::*;
#(
    parameter int NBINS = NBINS_DEFAULT,
    parameter int ACCW  = 32,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [ACCW-1:0] wdata,
    input  logic [AW-1:0]   acc_raddr,
    output logic [ACCW-1:0] acc_rdata,
    input  logic [AW-1:0]   emit_raddr,
    output logic [ACCW-1:0] emit_rdata
);

    logic [ACCW-1:0] mem [NBINS];

    // Single write port shared by clear sweep, accumulate and emit-clear.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign acc_rdata  = mem[acc_raddr];
    assign emit_rdata = mem[emit_raddr];

endmodule

// File: rtl/phcount_accumulator.sv
// Sums a batch of logger histogram frames bin-by-bin into saturating
// accumulators and emits one accumulated frame per batch to the pipe FIFO.
// The input side never stalls; headers arriving while busy are counted as drops.
module phcount_accumulator
    import phcount_accumulator_pkg::*;
#(
    parameter int NBINS = NBINS_DEFAULT,
    parameter int ACCW  = 32
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [15:0] data_i,
    input  logic        wr_i,
    input  logic [14:0] nframes_i,
    input  logic        cfg_ld_i,
    input  logic        full_i,
    output logic [15:0] data_o,
    output logic        wr_o,
    output logic        busy_o,
    output logic [15:0] dropped_o
);

    localparam int AW = (NBINS > 1) ? $clog2(NBINS) : 1;
    localparam int IW = $clog2(NBINS + 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NBINS - 1);
    localparam logic [IW-1:0] IDX_END   = IW'(NBINS);
    localparam logic [AW-1:0] EBIN_LAST = AW'(NBINS - 1);

    state_t          state;
    logic [IW-1:0]   idx;        // bin index for CLEAR sweep and ACC
    logic [AW-1:0]   ebin;       // bin index for emit
    logic [14:0]     frames;
    logic [14:0]     nframes_q;
    logic            err;

    logic            ram_we;
    logic [AW-1:0]   ram_waddr;
    logic [ACCW-1:0] ram_wdata;
    logic [ACCW-1:0] acc_rdata;
    logic [ACCW-1:0] emit_rdata;

    logic            is_hdr;
    logic            is_term;
    logic [14:0]     nf_eff;
    logic [14:0]     frames_inc;
    logic            batch_done;

    // Sum clamps at all-ones rather than wrapping.
    function automatic logic [ACCW-1:0] sat_add(input logic [ACCW-1:0] a,
                                                input logic [15:0]     b);
        logic [ACCW:0] s;
        s = {1'b0, a} + {{(ACCW-15){1'b0}}, b};
        return s[ACCW] ? {ACCW{1'b1}} : s[ACCW-1:0];
    endfunction

    assign is_hdr     = (data_i == HDR_LOG);
    assign is_term    = (data_i == TERM);
    assign nf_eff     = (nframes_q == 15'd0) ? 15'd1 : nframes_q;
    assign frames_inc = frames + 15'd1;
    assign batch_done = (frames_inc == nf_eff);
    assign busy_o     = state inside {ST_CLEAR, ST_EMIT_HDR, ST_EMIT_HI,
                                      ST_EMIT_LO, ST_EMIT_CNT, ST_EMIT_TERM};

    phacc_ram #(
        .NBINS (NBINS),
        .ACCW  (ACCW),
        .AW    (AW)
    ) u_ram (
        .clk        (clk_i),
        .we         (ram_we),
        .waddr      (ram_waddr),
        .wdata      (ram_wdata),
        .acc_raddr  (idx[AW-1:0]),
        .acc_rdata  (acc_rdata),
        .emit_raddr (ebin),
        .emit_rdata (emit_rdata)
    );

    // RAM write port: zero during CLEAR, read-modify-write in ACC,
    // zero each bin as its lo word leaves in EMIT_LO. cfg_ld_i discards the word.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = idx[AW-1:0];
        ram_wdata = '0;
        if (!reset_i && !cfg_ld_i) begin
            case (state)
                ST_CLEAR: ram_we = 1'b1;
                ST_ACC: begin
                    if (wr_i && !is_hdr && !is_term && (idx != IDX_END)) begin
                        ram_we    = 1'b1;
                        ram_wdata = sat_add(acc_rdata, bswap16(data_i));
                    end
                end
                ST_EMIT_LO: begin
                    if (!full_i) begin
                        ram_we    = 1'b1;
                        ram_waddr = ebin;
                    end
                end
                default: ;
            endcase
        end
    end

    // Main state machine with the registered FIFO output stage.
    always_ff @(posedge clk_i) begin
        if (reset_i || cfg_ld_i) begin
            state  <= ST_CLEAR;
            idx    <= '0;
            ebin   <= '0;
            frames <= '0;
            err    <= 1'b0;
            wr_o   <= 1'b0;
            if (reset_i) begin
                nframes_q <= 15'd1;
                data_o    <= 16'h0000;
            end else begin
                nframes_q <= nframes_i;
            end
        end else begin
            wr_o <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    if (idx == IDX_LAST) begin
                        idx   <= '0;
                        state <= ST_HUNT;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end

                ST_HUNT: begin
                    if (wr_i && is_hdr) begin
                        idx   <= '0;
                        state <= ST_ACC;
                    end
                end

                ST_ACC: begin
                    if (wr_i) begin
                        if (is_term) begin
                            frames <= frames_inc;
                            if (idx != IDX_END) begin
                                err <= 1'b1;
                            end
                            if (batch_done) begin
                                // Header goes out on the very next cycle when the FIFO has room.
                                ebin <= '0;
                                if (!full_i) begin
                                    data_o <= HDR_ACC;
                                    wr_o   <= 1'b1;
                                    state  <= ST_EMIT_HI;
                                end else begin
                                    state <= ST_EMIT_HDR;
                                end
                            end else begin
                                state <= ST_HUNT;
                            end
                        end else if (is_hdr) begin
                            err <= 1'b1;
                            idx <= '0;
                        end else if (idx != IDX_END) begin
                            idx <= idx + IW'(1);
                        end else begin
                            err   <= 1'b1;
                            state <= ST_HUNT;
                        end
                    end
                end

                ST_EMIT_HDR: begin
                    if (!full_i) begin
                        data_o <= HDR_ACC;
                        wr_o   <= 1'b1;
                        ebin   <= '0;
                        state  <= ST_EMIT_HI;
                    end
                end

                ST_EMIT_HI: begin
                    if (!full_i) begin
                        data_o <= bswap16(emit_rdata[ACCW-1 -: 16]);
                        wr_o   <= 1'b1;
                        state  <= ST_EMIT_LO;
                    end
                end

                ST_EMIT_LO: begin
                    if (!full_i) begin
                        data_o <= bswap16(emit_rdata[15:0]);
                        wr_o   <= 1'b1;
                        if (ebin == EBIN_LAST) begin
                            state <= ST_EMIT_CNT;
                        end else begin
                            ebin  <= ebin + AW'(1);
                            state <= ST_EMIT_HI;
                        end
                    end
                end

                ST_EMIT_CNT: begin
                    if (!full_i) begin
                        data_o <= {err, frames};
                        wr_o   <= 1'b1;
                        state  <= ST_EMIT_TERM;
                    end
                end

                ST_EMIT_TERM: begin
                    if (!full_i) begin
                        data_o <= TERM;
                        wr_o   <= 1'b1;
                        frames <= '0;
                        err    <= 1'b0;
                        state  <= ST_HUNT;
                    end
                end

                default: state <= ST_CLEAR;
            endcase
        end
    end

    // Saturating count of logger headers that arrived while busy.
    always_ff @(posedge clk_i) begin
        if (reset_i || cfg_ld_i) begin
            dropped_o <= 16'h0000;
        end else if (wr_i && is_hdr && busy_o && (dropped_o != 16'hFFFF)) begin
            dropped_o <= dropped_o + 16'h0001;
        end
    end

endmodule

// File: tb/tb_phcount_accumulator.sv
// Scoreboard bench for phcount_accumulator: a behavioural model predicts each
// accumulated frame as stimulus is driven; a monitor pops and compares on wr_o.
module tb_phcount_accumulator;
    import phcount_accumulator_pkg::*;

    localparam int NB = NBINS_DEFAULT;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [15:0] data_i = 16'h0000;
    logic        wr_i = 1'b0;
    logic [14:0] nframes_i = 15'd1;
    logic        cfg_ld_i = 1'b0;
    logic        full_i = 1'b0;
    logic [15:0] data_o;
    logic        wr_o;
    logic        busy_o;
    logic [15:0] dropped_o;

    always #5 clk = ~clk;

    phcount_accumulator #(.NBINS(NB), .ACCW(32)) dut (
        .clk_i     (clk),
        .reset_i   (reset_i),
        .data_i    (data_i),
        .wr_i      (wr_i),
        .nframes_i (nframes_i),
        .cfg_ld_i  (cfg_ld_i),
        .full_i    (full_i),
        .data_o    (data_o),
        .wr_o      (wr_o),
        .busy_o    (busy_o),
        .dropped_o (dropped_o)
    );

    int          checks = 0;
    int          errors = 0;
    int          nwr = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_w;
    logic [15:0] last_word = 16'h0000;

    logic [31:0] model_acc[NB];
    int          model_frames = 0;
    logic        model_err = 1'b0;
    int          model_nf = 1;

    function automatic logic [15:0] sw(input logic [15:0] w);
        return {w[7:0], w[15:8]};
    endfunction

    function automatic logic [15:0] rnd_word();
        logic [15:0] w;
        w = 16'($urandom);
        if (w == 16'hFEED || w == 16'h0FED) w = 16'h1234;
        return w;
    endfunction

    // Output monitor / scoreboard
    always @(negedge clk) begin
        if (wr_o === 1'b1) begin
            checks++;
            nwr++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got %h, expected no write", data_o);
            end else begin
                exp_w = exp_q.pop_front();
                last_word = exp_w;
                if (data_o !== exp_w) begin
                    errors++;
                    $display("FAIL out_word: got %h, expected %h", data_o, exp_w);
                end
            end
        end
    end

    task automatic idle(input int n);
        wr_i = 1'b0;
        data_i = 16'h0000;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_word(input logic [15:0] w);
        data_i = w;
        wr_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic model_clear();
        for (int k = 0; k < NB; k++) model_acc[k] = 32'h0;
        model_frames = 0;
        model_err = 1'b0;
    endtask

    task automatic do_cfg(input logic [14:0] nf);
        cfg_ld_i = 1'b1;
        nframes_i = nf;
        @(negedge clk);
        cfg_ld_i = 1'b0;
        model_clear();
        model_nf = (nf == 15'd0) ? 1 : int'(nf);
        repeat (NB + 1) @(negedge clk);
    endtask

    task automatic push_emit();
        logic [31:0] cur;
        logic [14:0] fr;
        exp_q.push_back(16'hFEEA);
        for (int k = 0; k < NB; k++) begin
            cur = model_acc[k];
            exp_q.push_back(sw(cur[31:16]));
            exp_q.push_back(sw(cur[15:0]));
        end
        fr = 15'(model_frames);
        exp_q.push_back({model_err, fr});
        exp_q.push_back(16'h0FED);
        model_clear();
    endtask

    task automatic send_frame(input logic [15:0] vals[NB], input int nsent, input bit accept);
        longint s;
        send_word(16'hFEED);
        for (int k = 0; k < nsent; k++) begin
            send_word(vals[k]);
            if (accept) begin
                s = longint'(model_acc[k]) + longint'(sw(vals[k]));
                model_acc[k] = (s > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
            end
        end
        if (accept) begin
            model_frames++;
            if (nsent != NB) model_err = 1'b1;
            if (model_frames == model_nf) push_emit();
        end
        send_word(16'h0FED);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        idle(4);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d words missing, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        checks++;
        if (wr_o !== 1'b0) begin errors++; $display("FAIL reset_wr_o: got %b, expected 0", wr_o); end
        checks++;
        if (data_o !== 16'h0000) begin errors++; $display("FAIL reset_data_o: got %h, expected 0000", data_o); end
        checks++;
        if (dropped_o !== 16'h0000) begin errors++; $display("FAIL reset_dropped: got %h, expected 0000", dropped_o); end
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b, expected 1", busy_o); end
        repeat (NB - 1) @(negedge clk);
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("FAIL clear_len_early: got busy %b, expected 1", busy_o); end
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL clear_len_end: got busy %b, expected 0", busy_o); end
    endtask

    task automatic test_single();
        logic [15:0] vals[NB];
        do_cfg(15'd1);
        for (int k = 0; k < NB; k++) vals[k] = sw(16'(k + 1));
        nwr = 0;
        send_frame(vals, NB, 1'b1);
        idle(0);
        checks++;
        if (wr_o !== 1'b1 || data_o !== 16'hFEEA) begin
            errors++;
            $display("FAIL latency: got wr_o=%b data_o=%h, expected 1 FEEA", wr_o, data_o);
        end
        wait_drain("single");
        checks++;
        if (nwr != 2 * NB + 3) begin errors++; $display("FAIL single_len: got %0d writes, expected %0d", nwr, 2 * NB + 3); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals[NB];
        do_cfg(15'd3);
        for (int k = 0; k < NB; k++) vals[k] = sw(16'hFFFF);
        send_frame(vals, NB, 1'b1);
        send_frame(vals, NB, 1'b1);
        send_frame(vals, NB, 1'b1);
        idle(0);
        wait_drain("back_to_back");
    endtask

    task automatic test_short_frame();
        logic [15:0] vals[NB];
        do_cfg(15'd2);
        for (int k = 0; k < NB; k++) vals[k] = rnd_word();
        send_frame(vals, NB - 1, 1'b1);
        idle(2);
        for (int k = 0; k < NB; k++) vals[k] = rnd_word();
        send_frame(vals, NB, 1'b1);
        idle(0);
        wait_drain("short_frame");
    endtask

    task automatic test_backpressure();
        logic [15:0] vals[NB];
        int remain;
        do_cfg(15'd1);
        for (int k = 0; k < NB; k++) vals[k] = rnd_word();
        nwr = 0;
        send_frame(vals, NB, 1'b1);
        idle(6);
        full_i = 1'b1;
        remain = exp_q.size();
        checks++;
        if (remain == 0) begin errors++; $display("FAIL hold_mid_emit: got %0d pending, expected >0", remain); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (wr_o !== 1'b0) begin errors++; $display("FAIL hold_wr_o: got %b, expected 0", wr_o); end
            checks++;
            if (data_o !== last_word) begin errors++; $display("FAIL hold_data_o: got %h, expected %h", data_o, last_word); end
        end
        full_i = 1'b0;
        wait_drain("backpressure");
        checks++;
        if (nwr != 2 * NB + 3) begin errors++; $display("FAIL bp_len: got %0d writes, expected %0d", nwr, 2 * NB + 3); end
    endtask

    task automatic test_drop();
        logic [15:0] vals[NB];
        do_cfg(15'd1);
        for (int k = 0; k < NB; k++) vals[k] = rnd_word();
        send_frame(vals, NB, 1'b1);
        idle(3);
        for (int k = 0; k < NB; k++) vals[k] = rnd_word();
        send_frame(vals, NB, 1'b0);
        wait_drain("drop_a");
        checks++;
        if (dropped_o !== 16'd1) begin errors++; $display("FAIL dropped: got %0d, expected 1", dropped_o); end
        for (int k = 0; k < NB; k++) vals[k] = rnd_word();
        send_frame(vals, NB, 1'b1);
        idle(0);
        wait_drain("drop_c");
        checks++;
        if (dropped_o !== 16'd1) begin errors++; $display("FAIL dropped_after: got %0d, expected 1", dropped_o); end
    endtask

    task automatic test_saturation();
        logic [15:0] vals[NB];
        do_cfg(15'd1);
        for (int k = 0; k < NB; k++) begin
            dut.u_ram.mem[k] = 32'hFFFF_FFF0;
            model_acc[k] = 32'hFFFF_FFF0;
            vals[k] = sw(16'(k));
        end
        vals[NB - 1] = 16'hFFFF;
        send_frame(vals, NB, 1'b1);
        idle(0);
        wait_drain("saturation");
    endtask

    task automatic test_nframes_zero();
        logic [15:0] vals[NB];
        do_cfg(15'd0);
        for (int k = 0; k < NB; k++) vals[k] = rnd_word();
        send_frame(vals, NB, 1'b1);
        idle(0);
        wait_drain("nframes_zero");
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single();
        test_back_to_back();
        test_short_frame();
        test_backpressure();
        test_drop();
        test_saturation();
        test_nframes_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
